serial_bit_packer: RTL

- Downstream consumer of the single-bit output of the 3-input/1-output combinational design-under-test stage.
- Collects that serial bit stream into WIDTH-bit words, LSB first.
- Queues completed words in a small FIFO and delivers them on a valid/ready interface to the testbench scoreboard or a capture block.
- Supports flushing a partial word and flags dropped data.

---
 rtl/serial_bit_packer_pkg.sv | 28 ++
 rtl/bit_packer_fifo.sv | 63 ++++++
 rtl/serial_bit_packer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/serial_bit_packer_pkg.sv
// -----------------------------------------------------------------------------
// serial_bit_packer_pkg
// Shared definitions for the serial bit packer and its FIFO.
//   DEF_WIDTH    : default bits per packed word
//   DEF_DEPTH    : default number of output FIFO entries
//   calc_len_w() : width needed to hold a word length of 0..width
//   fifo_entry_t : {len, data} layout of one queued word at default sizes
// -----------------------------------------------------------------------------
package serial_bit_packer_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 2;

    // A length can reach WIDTH itself, so one bit more than the index width.
    function automatic int calc_len_w(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int DEF_LEN_W = calc_len_w(DEF_WIDTH);

    // The RTL FIFO stores entries in this same {len, data} order as a flat
    // vector so that non-default WIDTH values still work.
    typedef struct packed {
        logic [DEF_LEN_W-1:0] len;
        logic [DEF_WIDTH-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/bit_packer_fifo.sv
// -----------------------------------------------------------------------------
// bit_packer_fifo
// Synchronous show-ahead FIFO. The head entry is presented combinationally on
// pop_data whenever empty=0. Push and pop may happen in the same cycle, also
// when full, because the popped slot is the one being overwritten.
//   clk, rst   : clock, asynchronous active-high reset (clears pointers)
//   push       : write push_data at the tail (caller guarantees room)
//   push_data  : entry to write
//   pop        : drop the head entry (caller guarantees non-empty)
//   pop_data   : current head entry
//   full/empty : occupancy flags
// -----------------------------------------------------------------------------
module bit_packer_fifo #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       ptr_one;

    assign ptr_one = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_one;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_one;
            end
        end
    end

    // Storage is not reset; its contents are only observed while non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/serial_bit_packer.sv
// -----------------------------------------------------------------------------
// serial_bit_packer
// Packs a serial bit stream LSB first into WIDTH-bit words, queues completed
// or flushed words in a small FIFO and offers them on a valid/ready interface.
//   clk, rst    : clock, asynchronous active-high reset
//   bit_in      : serial data bit
//   bit_valid   : bit_in is valid this cycle
//   flush       : emit the pending partial word (after any same-cycle bit)
//   word_out    : head word, zero when word_valid=0
//   word_len    : valid bits in word_out (1..WIDTH), zero when word_valid=0
//   word_valid  : FIFO non-empty
//   word_ready  : consumer takes the head word
//   overflow    : sticky flag, a bit or flush was refused for lack of room
//   clear_ovf   : clears overflow (a same-cycle drop wins)
//   busy        : a partial word is pending
// -----------------------------------------------------------------------------
module serial_bit_packer
    import serial_bit_packer_pkg::*;
#(
    parameter int   WIDTH = DEF_WIDTH,
    parameter int   DEPTH = DEF_DEPTH,
    localparam int  LEN_W = calc_len_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             flush,
    output logic [WIDTH-1:0] word_out,
    output logic [LEN_W-1:0] word_len,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overflow,
    input  logic             clear_ovf,
    output logic             busy
);

    localparam int IDX_W   = $clog2(WIDTH);
    localparam int ENTRY_W = LEN_W + WIDTH;

    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]   eff_acc;
    logic [IDX_W-1:0]   cnt;
    logic [IDX_W-1:0]   cnt_next;
    logic [LEN_W-1:0]   eff_cnt;
    logic               ovf_q;
    logic               set_ovf;
    logic               push;
    logic               pop;
    logic               can_push;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;

    // Full implies non-empty, so a pop this cycle always frees a slot.
    assign pop      = !fifo_empty && word_ready;
    assign can_push = !fifo_full || pop;

    // eff_acc/eff_cnt describe the partial word after the same-cycle bit, so
    // flush sees it. A completing bit that cannot be pushed leaves acc and
    // cnt untouched so the upstream can re-present it. Bits above cnt in acc
    // are always zero, which gives flushed words their zero upper bits.
    always_comb begin
        eff_acc    = acc;
        eff_cnt    = LEN_W'(cnt);
        acc_next   = acc;
        cnt_next   = cnt;
        push       = 1'b0;
        push_entry = '0;
        set_ovf    = 1'b0;

        if (bit_valid) begin
            eff_acc[cnt] = bit_in;
            eff_cnt      = LEN_W'(cnt) + LEN_W'(1);
        end

        if (bit_valid && (cnt == IDX_W'(WIDTH - 1))) begin
            if (can_push) begin
                push       = 1'b1;
                push_entry = {LEN_W'(WIDTH), eff_acc};
                acc_next   = '0;
                cnt_next   = '0;
            end else begin
                set_ovf = 1'b1;
            end
        end else if (flush && (eff_cnt != '0)) begin
            if (can_push) begin
                push       = 1'b1;
                push_entry = {eff_cnt, eff_acc};
                acc_next   = '0;
                cnt_next   = '0;
            end else begin
                set_ovf  = 1'b1;
                acc_next = eff_acc;
                cnt_next = eff_cnt[IDX_W-1:0];
            end
        end else begin
            acc_next = eff_acc;
            cnt_next = eff_cnt[IDX_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc <= acc_next;
            cnt <= cnt_next;
            if (set_ovf) begin
                ovf_q <= 1'b1;
            end else if (clear_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    bit_packer_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign word_valid = !fifo_empty;
    assign word_out   = fifo_empty ? '0 : head_entry[WIDTH-1:0];
    assign word_len   = fifo_empty ? '0 : head_entry[ENTRY_W-1:WIDTH];
    assign busy       = (cnt != '0);
    assign overflow   = ovf_q;

endmodule
